// File: rtl/synthesizer_adsr_envelope_if.sv
// synthesizer_adsr_envelope_if: control, time/level and envelope output bundle for one ADSR voice
// SYNTH_ADSR_VELOCITY_EN adds the 7-bit velocity input.
interface synthesizer_adsr_envelope_if #(parameter int ENV_W = 16);
  logic             sample_tick;
  logic             gate_on;
  logic             gate_off;
  logic [7:0]       attack_time;
  logic [7:0]       decay_time;
  logic [7:0]       sustain_level;
  logic [7:0]       release_time;
`ifdef SYNTH_ADSR_VELOCITY_EN
  logic [6:0]       velocity;
`endif
  logic [ENV_W-1:0] env_out;
  logic             env_valid;
  logic             busy;
  logic [2:0]       state_o;
  modport master (
`ifdef SYNTH_ADSR_VELOCITY_EN
    output velocity,
`endif
    output sample_tick, gate_on, gate_off, attack_time, decay_time, sustain_level, release_time,
    input  env_out, env_valid, busy, state_o
  );
  modport slave (
`ifdef SYNTH_ADSR_VELOCITY_EN
    input  velocity,
`endif
    input  sample_tick, gate_on, gate_off, attack_time, decay_time, sustain_level, release_time,
    output env_out, env_valid, busy, state_o
  );
endinterface

// File: rtl/synthesizer_adsr_envelope.sv
// synthesizer_adsr_envelope: per-voice ADSR envelope stepped on sample ticks
// SYNTH_ADSR_VELOCITY_EN adds velocity scaling with one extra output stage.
module synthesizer_adsr_envelope #(parameter int ENV_W = 16) (
  input logic                           clk,
  input logic                           reset,
  synthesizer_adsr_envelope_if.slave    bus
);
  localparam logic [ENV_W-1:0] STEP    = ENV_W'(1) << (ENV_W - 8);
  localparam logic [ENV_W-1:0] ENV_MAX = '1;
  typedef enum logic [2:0] {IDLE = 3'd0, ATTACK = 3'd1, DECAY = 3'd2, SUSTAIN = 3'd3, RELEASE = 3'd4} state_t;
  state_t           r_state, w_state_nxt;
  logic [ENV_W-1:0] r_env, w_env_nxt, w_sus, r_env_out;
  logic [ENV_W:0]   w_sus_step;
  logic [7:0]       r_div, w_div_nxt, w_t;
  logic             r_env_valid, r_busy;
  assign w_sus      = {bus.sustain_level, {(ENV_W-8){1'b0}}};
  // one extra bit so a sustain target near full scale cannot wrap
  assign w_sus_step = {1'b0, w_sus} + {1'b0, STEP};
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_div_nxt   = r_div;
    w_t = r_state == ATTACK ? bus.attack_time : r_state == DECAY ? bus.decay_time : bus.release_time;
    if (bus.gate_on) begin
      w_state_nxt = ATTACK;
      w_div_nxt   = '0;
    end else if (bus.gate_off && r_state inside {ATTACK, DECAY, SUSTAIN}) begin
      w_state_nxt = RELEASE;
      w_div_nxt   = '0;
    end else if (bus.sample_tick && r_state inside {ATTACK, DECAY, RELEASE}) begin
      if (r_div < w_t) begin
        w_div_nxt = r_div + 8'd1;
      end else begin
        w_div_nxt = '0;
        case (r_state)
          ATTACK: begin
            w_env_nxt   = r_env > ENV_MAX - STEP ? ENV_MAX : r_env + STEP;
            w_state_nxt = r_env > ENV_MAX - STEP ? DECAY : ATTACK;
          end
          DECAY: begin
            w_env_nxt   = {1'b0, r_env} <= w_sus_step ? w_sus : r_env - STEP;
            w_state_nxt = {1'b0, r_env} <= w_sus_step ? SUSTAIN : DECAY;
          end
          default: begin
            w_env_nxt   = r_env <= STEP ? '0 : r_env - STEP;
            w_state_nxt = r_env <= STEP ? IDLE : RELEASE;
          end
        endcase
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_env   <= '0;
      r_div   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
      r_div   <= w_div_nxt;
      r_busy  <= w_state_nxt != IDLE;
    end
  end
`ifdef SYNTH_ADSR_VELOCITY_EN
  logic [6:0]       r_vel;
  logic [ENV_W-1:0] r_env_s1;
  logic             r_valid_s1;
  logic [ENV_W+7:0] w_prod;
  assign w_prod = {8'd0, r_env_s1} * {{ENV_W{1'b0}}, {1'b0, r_vel} + 8'd1};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vel       <= '0;
      r_env_s1    <= '0;
      r_valid_s1  <= 1'b0;
      r_env_out   <= '0;
      r_env_valid <= 1'b0;
    end else begin
      if (bus.gate_on) r_vel <= bus.velocity;
      r_env_s1    <= w_env_nxt;
      r_valid_s1  <= bus.sample_tick;
      r_env_valid <= r_valid_s1;
      if (r_valid_s1) r_env_out <= w_prod[ENV_W+6:7];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_env_out   <= '0;
      r_env_valid <= 1'b0;
    end else begin
      r_env_valid <= bus.sample_tick;
      if (bus.sample_tick) r_env_out <= w_env_nxt;
    end
  end
`endif
  assign bus.env_out   = r_env_out;
  assign bus.env_valid = r_env_valid;
  assign bus.busy      = r_busy;
  assign bus.state_o   = r_state;
endmodule
